// File: rtl/alu_seq_core_if.sv
// Request/response bundle for alu_seq_core: operand request handshake plus
// result/flags handshake. The core connects through the slave modport.
interface alu_seq_core_if #(
  parameter int unsigned WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     operand_a;
  logic [WIDTH-1:0]     operand_b;
  logic [3:0]           opcode;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   result;
  logic [4:0]           flags;

  modport master (
    output in_valid, operand_a, operand_b, opcode, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, operand_a, operand_b, opcode, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/alu_seq_core.sv
// Handshaked signed ALU: single-cycle logic/arith ops, iterative WIDTH-step
// shift-add multiply and restoring divide. One operation in flight at a time.
module alu_seq_core #(
  parameter int unsigned WIDTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  alu_seq_core_if.slave bus
);
  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned RW  = 2 * WIDTH;
  localparam logic [SHW-1:0] CNT_LAST  = SHW'(WIDTH - 1);
  localparam logic [WIDTH:0] SHIFT_LIM = (WIDTH + 1)'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_XOR,
    OP_SHL, OP_SHR, OP_INC, OP_DEC
  } op_e;

  state_e           r_state, w_next;
  logic [SHW-1:0]   r_cnt;
  logic             r_is_div, r_neg;
  logic [RW-1:0]    r_acc, r_mcand;
  logic [WIDTH-1:0] r_mq, r_dvsr, r_rem;
  logic [RW-1:0]    r_result;
  logic [4:0]       r_flags;

  logic             w_accept, w_last;
  logic [WIDTH-1:0] w_a, w_b, w_abs_a, w_abs_b, w_wide;
  logic             w_ovf, w_ill, w_dz, w_go_busy;
  logic [RW-1:0]    w_simple_res;
  logic [4:0]       w_simple_flags;
  logic [RW-1:0]    w_mul_acc, w_mag, w_fin;
  logic [WIDTH:0]   w_rem_sh, w_diff;
  logic [WIDTH-1:0] w_quo_nx, w_rem_nx;
  logic [4:0]       w_fin_flags;

  assign bus.in_ready  = (r_state == S_IDLE) && reset;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.result    = r_result;
  assign bus.flags     = r_flags;

  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_last   = (r_cnt == CNT_LAST);
  assign w_a      = bus.operand_a;
  assign w_b      = bus.operand_b;
  assign w_abs_a  = w_a[WIDTH-1] ? (~w_a + 1'b1) : w_a;
  assign w_abs_b  = w_b[WIDTH-1] ? (~w_b + 1'b1) : w_b;

  // Single-cycle ops resolved from the live request at the accept edge.
  always_comb begin
    w_wide    = '0;
    w_ovf     = 1'b0;
    w_ill     = 1'b0;
    w_dz      = 1'b0;
    w_go_busy = 1'b0;
    case (bus.opcode)
      OP_ADD: begin
        w_wide = w_a + w_b;
        w_ovf  = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_wide[WIDTH-1] != w_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_wide = w_a - w_b;
        w_ovf  = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_wide[WIDTH-1] != w_a[WIDTH-1]);
      end
      OP_INC: begin
        w_wide = w_a + 1'b1;
        w_ovf  = !w_a[WIDTH-1] && w_wide[WIDTH-1];
      end
      OP_DEC: begin
        w_wide = w_a - 1'b1;
        w_ovf  = w_a[WIDTH-1] && !w_wide[WIDTH-1];
      end
      OP_MUL: w_go_busy = 1'b1;
      OP_DIV: begin
        if (w_b == '0) w_dz = 1'b1;
        else           w_go_busy = 1'b1;
      end
      OP_AND: w_wide = w_a & w_b;
      OP_OR:  w_wide = w_a | w_b;
      OP_XOR: w_wide = w_a ^ w_b;
      OP_SHL: w_wide = ({1'b0, w_b} >= SHIFT_LIM) ? '0 : (w_a << w_b[SHW-1:0]);
      OP_SHR: w_wide = ({1'b0, w_b} >= SHIFT_LIM) ? '0 : (w_a >> w_b[SHW-1:0]);
      default: w_ill = 1'b1;
    endcase
    w_simple_res   = {{WIDTH{w_wide[WIDTH-1]}}, w_wide};
    w_simple_flags = {w_ill, w_dz, w_ovf, w_simple_res[RW-1], w_simple_res == '0};
  end

  // One iteration step; on the last step the sign fix-up is folded into w_fin.
  always_comb begin
    w_mul_acc   = r_acc + (r_mq[0] ? r_mcand : '0);
    w_rem_sh    = {r_rem, r_mq[WIDTH-1]};
    w_diff      = w_rem_sh - {1'b0, r_dvsr};
    w_rem_nx    = w_diff[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
    w_quo_nx    = {r_mq[WIDTH-2:0], !w_diff[WIDTH]};
    w_mag       = r_is_div ? {{WIDTH{1'b0}}, w_quo_nx} : w_mul_acc;
    w_fin       = r_neg ? ('0 - w_mag) : w_mag;
    w_fin_flags = {2'b00, r_is_div && !r_neg && w_quo_nx[WIDTH-1],
                   w_fin[RW-1], w_fin == '0};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_go_busy ? S_BUSY : S_DONE;
      S_BUSY:  if (w_last) w_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg    <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mq     <= '0;
      r_dvsr   <= '0;
      r_rem    <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_cnt    <= '0;
          r_is_div <= (bus.opcode == OP_DIV);
          r_neg    <= w_a[WIDTH-1] ^ w_b[WIDTH-1];
          r_acc    <= '0;
          r_rem    <= '0;
          r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
          r_mq     <= (bus.opcode == OP_DIV) ? w_abs_a : w_abs_b;
          r_dvsr   <= w_abs_b;
          r_result <= w_simple_res;
          r_flags  <= w_go_busy ? 5'b0 : w_simple_flags;
        end
        S_BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_is_div) begin
            r_rem <= w_rem_nx;
            r_mq  <= w_quo_nx;
          end else begin
            r_acc   <= w_mul_acc;
            r_mcand <= r_mcand << 1;
            r_mq    <= r_mq >> 1;
          end
          if (w_last) begin
            r_result <= w_fin;
            r_flags  <= w_fin_flags;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
- Parametrised successor to the single-cycle 16-bit ALU; same opcode map, generalised to WIDTH-bit signed operands with a 2*WIDTH-bit result.
- Adds valid/ready handshakes on input and output, iterative multicycle multiply/divide, and a status flag vector.
- Sits between the operand register file and the result writeback/cache path; one operation in flight at a time.

Parameters:
- WIDTH, 16, operand width in bits (>=4); result is 2*WIDTH bits.
- SHW, $clog2(WIDTH), shift-amount field width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  operation request valid
- in_ready  output  1  core can accept a request
- operand_a  input  WIDTH  signed operand A
- operand_b  input  WIDTH  signed operand B
- opcode  input  4  operation select
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer accepts result
- result  output  2*WIDTH  signed result
- flags  output  5  {illegal, div_by_zero, overflow, negative, zero}

Behaviour:
- Opcodes: 0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 xor, 7 shl, 8 shr, 9 inc (A+1), 10 dec (A-1), 11-15 illegal.
- Reset (reset=0, async): state IDLE, in_ready=0 while asserted then 1, out_valid=0, result=0, flags=0, counter cleared. Reset mid-BUSY or mid-DONE discards the operation.
- FSM: IDLE -> accept when in_valid&&in_ready; operands/opcode latched. Simple ops and illegal ops -> DONE next cycle. Mul/div with nonzero divisor -> BUSY. Div by zero -> DONE next cycle.
- BUSY: one shift-add (mul) or restoring-subtract (div) step per cycle on magnitudes, WIDTH steps; sign fix-up applied on the last step; then DONE.
- DONE: out_valid=1; result and flags held stable until out_ready=1; then IDLE next cycle.
- in_ready=1 only in IDLE. Input is ignored in BUSY/DONE.
- Latency, accept edge to out_valid: simple/illegal/div0 = 1 cycle; mul/div = WIDTH+1 cycles.
- add/sub/inc/dec: WIDTH-bit wrapped result, sign-extended to 2*WIDTH. overflow=1 on signed WIDTH overflow.
- mul: full 2*WIDTH signed product; overflow=0.
- div: quotient truncated toward zero, sign-extended. Remainder discarded. MIN/-1 gives +2^(WIDTH-1) in 2*WIDTH with overflow=1.
- div by zero: result=0, div_by_zero=1.
- and/or/xor: WIDTH-bit result, sign-extended.
- shl/shr: logical on WIDTH bits by operand_b[SHW-1:0]; operand_b >= WIDTH yields 0. Result is sign-extended from bit WIDTH-1.
- illegal: result=0, illegal=1.
- zero/negative: computed on the full 2*WIDTH result, for every op.
- Flags are cleared on each new accept.

Test Plan:
- WIDTH=16, add -10 + -11 -> out_valid 1 cycle after accept; result=-21 (32-bit); flags=00010. Then 32767+1 -> result=-32768, overflow=1, negative=1.
- mul 10*3 and -7*6 -> out_valid exactly 17 cycles after accept; results 30 and -42. in_ready=0 throughout BUSY; a request presented during BUSY is not accepted.
- div 25/3=8, -25/3=-8, -32768/-1 -> 32768 with overflow=1. 5/0 -> result 0, div_by_zero=1, latency 1.
- shl 10<<2=40, shr 138>>4=8, shr by 16 -> 0; opcode 13 -> result 0, illegal=1; dec 0 -> -1, negative=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result/flags/out_valid stable; in_ready returns 1 one cycle after out_ready=1.
- Assert reset mid-division (cycle 8 of BUSY) -> out_valid=0 and result=0 immediately. After release, a fresh add 1+1 returns 2 with clean flags.
